// File: rtl/mem_responder_if.sv
// Signal bundle between mem_responder, its requesters (iREN/dREN/dWEN side) and the RAM model.
// slave = the responder itself; master = everything around it (requesters plus RAM).
interface mem_responder_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_responder.sv
// Single-ported RAM responder: data-priority arbitration, one transaction at a time, one-cycle hit pulses.
// Optional access watchdog compiled in with MEM_RESPONDER_TIMEOUT_EN (adds TIMEOUT parameter and timeout port).
module mem_responder
`ifdef MEM_RESPONDER_TIMEOUT_EN
#(
    parameter int TIMEOUT = 64
)
`endif
(
    input  logic           CLK,
    input  logic           nRST,
`ifdef MEM_RESPONDER_TIMEOUT_EN
    output logic           timeout,
`endif
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_state_t;

    typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

    state_t      r_state;
    logic        r_wr;
    logic        r_ihit;
    logic        r_dhit;
    logic        r_ren;
    logic        r_wen;
    logic [31:0] r_ramaddr;
    logic [31:0] r_ramstore;
    logic [31:0] r_iload;
    logic [31:0] r_dload;

    logic        w_access;
    logic        w_done;
    logic [31:0] w_load;

    assign w_access = (bus.ramstate == RAM_ACCESS);

`ifdef MEM_RESPONDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    logic          w_expire;

    // A real ACCESS on the last allowed cycle still wins over the watchdog.
    assign w_expire = !w_access && (r_cnt == CW'(TIMEOUT - 1));
    assign w_done   = w_access || w_expire;
    assign w_load   = w_access ? bus.ramload : 32'hBAD1BAD1;
    assign timeout  = r_timeout;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_state == DACC || r_state == IACC) begin
            if (w_expire)
                r_timeout <= 1'b1;
            if (r_cnt != CW'(TIMEOUT))
                r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_done = w_access;
    assign w_load = bus.ramload;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_ren      <= 1'b0;
            r_wen      <= 1'b0;
            r_ramaddr  <= 32'h0;
            r_ramstore <= 32'h0;
            r_iload    <= 32'h0;
            r_dload    <= 32'h0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.dREN || bus.dWEN) begin
                        // Write wins when both data strobes are up.
                        r_wr       <= bus.dWEN;
                        r_ren      <= !bus.dWEN;
                        r_wen      <= bus.dWEN;
                        r_ramaddr  <= bus.daddr;
                        r_ramstore <= bus.dstore;
                        r_state    <= DACC;
                    end else if (bus.iREN) begin
                        r_wr       <= 1'b0;
                        r_ren      <= 1'b1;
                        r_wen      <= 1'b0;
                        r_ramaddr  <= bus.iaddr;
                        r_ramstore <= 32'h0;
                        r_state    <= IACC;
                    end
                end
                DACC: begin
                    if (w_done) begin
                        if (!r_wr)
                            r_dload <= w_load;
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_dhit  <= 1'b1;
                        r_state <= DRESP;
                    end
                end
                IACC: begin
                    if (w_done) begin
                        r_iload <= w_load;
                        r_ren   <= 1'b0;
                        r_ihit  <= 1'b1;
                        r_state <= IRESP;
                    end
                end
                DRESP:   r_state <= IDLE;
                IRESP:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ihit     = r_ihit;
    assign bus.iload    = r_iload;
    assign bus.dhit     = r_dhit;
    assign bus.dload    = r_dload;
    assign bus.ramREN   = r_ren;
    assign bus.ramWEN   = r_wen;
    assign bus.ramaddr  = r_ramaddr;
    assign bus.ramstore = r_ramstore;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: transaction-level reference model compared every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_mem_responder;
    localparam int TMO = 8;

    logic CLK;
    logic nRST;
    mem_responder_if bus ();

`ifdef MEM_RESPONDER_TIMEOUT_EN
    logic timeout;
    mem_responder #(.TIMEOUT(TMO)) dut (.CLK(CLK), .nRST(nRST), .timeout(timeout), .bus(bus));
`else
    mem_responder dut (.CLK(CLK), .nRST(nRST), .bus(bus));
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, phase 0=idle 1=at RAM 2=responding.
    typedef struct packed {
        logic        d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        cur;
    int          phase;
    int          acc;
    logic [31:0] m_iload, m_dload;
    logic        m_to;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur     <= '0;
            phase   <= 0;
            acc     <= 0;
            m_iload <= 32'h0;
            m_dload <= 32'h0;
            m_to    <= 1'b0;
        end else if (phase == 0) begin
            acc <= 0;
            if (bus.dREN || bus.dWEN) begin
                cur   <= '{d: 1'b1, wr: bus.dWEN, addr: bus.daddr, data: bus.dstore};
                phase <= 1;
            end else if (bus.iREN) begin
                cur   <= '{d: 1'b0, wr: 1'b0, addr: bus.iaddr, data: 32'h0};
                phase <= 1;
            end
        end else if (phase == 1) begin
            acc <= acc + 1;
            if (bus.ramstate == 2'd2) begin
                phase <= 2;
                if (!cur.wr) begin
                    if (cur.d) m_dload <= bus.ramload;
                    else       m_iload <= bus.ramload;
                end
            end
`ifdef MEM_RESPONDER_TIMEOUT_EN
            else if (acc + 1 == TMO) begin
                phase <= 2;
                m_to  <= 1'b1;
                if (!cur.wr) begin
                    if (cur.d) m_dload <= 32'hBAD1BAD1;
                    else       m_iload <= 32'hBAD1BAD1;
                end
            end
`endif
        end else begin
            phase <= 0;
        end
    end

    logic e_ren, e_wen, e_ihit, e_dhit;
    assign e_ren  = (phase == 1) && !cur.wr;
    assign e_wen  = (phase == 1) && cur.wr;
    assign e_ihit = (phase == 2) && !cur.d;
    assign e_dhit = (phase == 2) && cur.d;

    bit started = 1'b0;

    always @(negedge CLK) begin
        if (started && nRST) begin
            chk("ihit",   32'(bus.ihit),   32'(e_ihit));
            chk("dhit",   32'(bus.dhit),   32'(e_dhit));
            chk("ramREN", 32'(bus.ramREN), 32'(e_ren));
            chk("ramWEN", 32'(bus.ramWEN), 32'(e_wen));
            chk("iload",  bus.iload,       m_iload);
            chk("dload",  bus.dload,       m_dload);
            if (e_ren || e_wen) chk("ramaddr", bus.ramaddr, cur.addr);
            if (e_wen)          chk("ramstore", bus.ramstore, cur.data);
`ifdef MEM_RESPONDER_TIMEOUT_EN
            chk("timeout", 32'(timeout), 32'(m_to));
`endif
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000");
        $fatal(1);
    end

    int ndh;

    initial begin
        nRST = 1'b1;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
        #2 nRST = 1'b0;
        #1;
        chk("rst_ihit",   32'(bus.ihit),   0);
        chk("rst_dhit",   32'(bus.dhit),   0);
        chk("rst_ramREN", 32'(bus.ramREN), 0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_iload",   bus.iload,   0);
        chk("rst_dload",   bus.dload,   0);
        repeat (2) cyc();
        nRST = 1'b1;
        started = 1'b1;
        cyc();

        // Instruction read, zero-wait RAM.
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'd2; bus.ramload = 32'h8C220004;
        cyc();
        chk("i_c1_ramREN", 32'(bus.ramREN), 1);
        chk("i_c1_ramaddr", bus.ramaddr, 32'h40);
        cyc();
        chk("i_c2_ihit", 32'(bus.ihit), 1);
        chk("i_c2_iload", bus.iload, 32'h8C220004);
        bus.iREN = 0;
        cyc();
        chk("i_c3_ihit", 32'(bus.ihit), 0);

        // Data and instruction together: data first.
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100; bus.ramload = 32'h11112222;
        cyc();
        chk("arb_c1_ramaddr", bus.ramaddr, 32'h100);
        cyc();
        chk("arb_c2_dhit", 32'(bus.dhit), 1);
        chk("arb_c2_ihit", 32'(bus.ihit), 0);
        chk("arb_c2_dload", bus.dload, 32'h11112222);
        bus.dREN = 0; bus.ramload = 32'h33334444;
        cyc();
        cyc();
        chk("arb_c4_ramaddr", bus.ramaddr, 32'h44);
        cyc();
        chk("arb_c5_ihit", 32'(bus.ihit), 1);
        chk("arb_c5_iload", bus.iload, 32'h33334444);
        bus.iREN = 0;
        cyc();

        // Write with three BUSY cycles.
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        bus.ramstate = 2'd1; bus.ramload = 32'hFFFFFFFF;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("wr_ramWEN", 32'(bus.ramWEN), 1);
            chk("wr_ramREN", 32'(bus.ramREN), 0);
            chk("wr_ramstore", bus.ramstore, 32'hDEADBEEF);
            if (k == 4) bus.ramstate = 2'd2;
        end
        cyc();
        chk("wr_c5_dhit", 32'(bus.dhit), 1);
        chk("wr_dload_kept", bus.dload, 32'h11112222);
        bus.dWEN = 0;
        cyc();

        // dREN and dWEN together: write only.
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h12345678;
        cyc();
        chk("rw_ramWEN", 32'(bus.ramWEN), 1);
        chk("rw_ramREN", 32'(bus.ramREN), 0);
        cyc();
        chk("rw_dhit", 32'(bus.dhit), 1);
        chk("rw_dload_kept", bus.dload, 32'h11112222);
        bus.dREN = 0; bus.dWEN = 0;
        cyc();

        // ERROR retries the read.
        bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = 2'd3; bus.ramload = 32'h55AA55AA;
        cyc();
        chk("err_c1_ramREN", 32'(bus.ramREN), 1);
        cyc();
        chk("err_c2_ramREN", 32'(bus.ramREN), 1);
        chk("err_c2_dhit", 32'(bus.dhit), 0);
        bus.ramstate = 2'd2;
        cyc();
        chk("err_c3_dhit", 32'(bus.dhit), 1);
        chk("err_c3_dload", bus.dload, 32'h55AA55AA);
        bus.dREN = 0;
        cyc();

        // Reset in the middle of a data access.
        bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = 2'd1; bus.ramload = 32'h77778888;
        cyc();
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_ramREN", 32'(bus.ramREN), 0);
        chk("mid_rst_ramaddr", bus.ramaddr, 0);
        chk("mid_rst_dload", bus.dload, 0);
        chk("mid_rst_dhit", 32'(bus.dhit), 0);
        cyc();
        chk("mid_rst_dhit_hold", 32'(bus.dhit), 0);
        nRST = 1'b1; bus.ramstate = 2'd2;
        cyc();
        chk("reissue_ramaddr", bus.ramaddr, 32'h500);
        cyc();
        chk("reissue_dhit", 32'(bus.dhit), 1);
        chk("reissue_dload", bus.dload, 32'h77778888);
        bus.dREN = 0;
        cyc();

        // Continuous instruction fetch with one data request slipped in.
        bus.iREN = 1; bus.iaddr = 32'h80;
        ndh = 0;
        for (int i = 0; i < 16; i++) begin
            bus.ramload = 32'h1000 + 32'(i);
            if (i == 5) begin bus.dREN = 1; bus.daddr = 32'h600; end
            cyc();
            if (bus.dhit) begin ndh++; bus.dREN = 0; end
        end
        bus.iREN = 0;
        repeat (3) cyc();
        chk("cont_dhit_count", 32'(ndh), 1);

`ifdef MEM_RESPONDER_TIMEOUT_EN
        // RAM stuck BUSY on a read: watchdog completes it.
        bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = 2'd1;
        for (int k = 1; k <= TMO; k++) begin
            cyc();
            chk("tmo_wait_dhit", 32'(bus.dhit), 0);
            chk("tmo_wait_ramREN", 32'(bus.ramREN), 1);
        end
        cyc();
        chk("tmo_dhit", 32'(bus.dhit), 1);
        chk("tmo_dload", bus.dload, 32'hBAD1BAD1);
        chk("tmo_flag", 32'(timeout), 1);
        bus.dREN = 0; bus.ramstate = 2'd2;
        repeat (3) cyc();
        chk("tmo_sticky", 32'(timeout), 1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
